// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
//   mode_t     : pattern mode encoding (2 bits)
//   dir_t      : bounce direction
//   cnt_width  : bits needed for a counter running 0..n-1 (never less than 1)
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L  = 2'd0,
      MODE_ROT_R  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FILL   = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, press pulse.
// Ports:
//   CLK    in   system clock
//   nRST   in   asynchronous active-low reset
//   btn_n  in   raw button, active-low, asynchronous to CLK
//   press  out  one-cycle pulse when the debounced level falls 1->0
module btn_debounce
   import led_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 540_000
) (
   input  logic CLK,
   input  logic nRST,
   input  logic btn_n,
   output logic press
);

   localparam int unsigned     DB_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync_q1;
   logic            sync_q2;
   logic            level_q;
   logic [DB_W-1:0] stable_cnt;

   // Down-counter reloads whenever the synchronised sample agrees with the
   // accepted level, so only an unbroken run of differing samples reaches zero.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sync_q1    <= 1'b1;
         sync_q2    <= 1'b1;
         level_q    <= 1'b1;
         stable_cnt <= DB_LOAD;
         press      <= 1'b0;
      end else begin
         sync_q1 <= btn_n;
         sync_q2 <= sync_q1;
         press   <= 1'b0;
         if (sync_q2 == level_q) begin
            stable_cnt <= DB_LOAD;
         end else if (stable_cnt == '0) begin
            level_q    <= sync_q2;
            stable_cnt <= DB_LOAD;
            // old level 1 means this flip is a press; releases give no pulse
            press      <= level_q;
         end else begin
            stable_cnt <= stable_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_pattern_seq.sv
// N-LED pattern sequencer: rotate-left, rotate-right, bounce and bar-fill,
// stepped by an exact-period prescaler; a debounced button cycles the mode.
// Optional feature macro: LED_SEQ_SPEED_EN (adds speed_i, period = STEP_CYCLES >> speed_i).
// Ports:
//   CLK      in   system clock
//   nRST     in   asynchronous active-low reset
//   btn_n    in   raw user button, active-low
//   pause_i  in   1 freezes prescaler and pattern
//   speed_i  in   step-rate select (LED_SEQ_SPEED_EN only)
//   LED      out  LED pins (inverted when ACTIVE_LOW)
//   mode_o   out  current mode
//   step_o   out  one-cycle pulse per pattern step
//
// mode        | meaning
// ------------+------------------------------------------
// MODE_ROT_L  | single lit LED walks towards bit N-1, wraps
// MODE_ROT_R  | single lit LED walks towards bit 0, wraps
// MODE_BOUNCE | single lit LED sweeps back and forth, no end dwell
// MODE_FILL   | bar grows from bit 0, then all off, then restarts
module led_pattern_seq
   import led_seq_pkg::*;
#(
   parameter int unsigned N_LEDS          = 6,
   parameter int unsigned STEP_CYCLES     = 13_500_000,
   parameter int unsigned DEBOUNCE_CYCLES = 540_000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              btn_n,
   input  logic              pause_i,
`ifdef LED_SEQ_SPEED_EN
   input  logic [1:0]        speed_i,
`endif
   output logic [N_LEDS-1:0] LED,
   output logic [1:0]        mode_o,
   output logic              step_o
);

   localparam int unsigned       PRE_W    = cnt_width(STEP_CYCLES);
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_CYCLES - 1);
   localparam logic [N_LEDS-1:0] PAT_INIT = N_LEDS'(1);

   logic [PRE_W-1:0]  pre_cnt;
   logic [PRE_W-1:0]  pre_last;
   logic              tick;
   logic              press;
   mode_t             mode_q;
   dir_t              dir_q;
   dir_t              dir_next;
   logic [N_LEDS-1:0] pat_q;
   logic [N_LEDS-1:0] pat_next;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .CLK  (CLK),
      .nRST (nRST),
      .btn_n(btn_n),
      .press(press)
   );

`ifdef LED_SEQ_SPEED_EN
   localparam logic [PRE_W:0] STEP_FULL = (PRE_W+1)'(STEP_CYCLES);

   logic [PRE_W:0]   step_scaled;
   logic [PRE_W-1:0] last_sel;
   logic [PRE_W-1:0] last_q;

   // Periods that shift down to 0 or 1 both mean "step every clock".
   always_comb begin
      step_scaled = STEP_FULL >> speed_i;
      last_sel    = (step_scaled <= (PRE_W+1)'(1)) ? '0 : PRE_W'(step_scaled - 1'b1);
   end

   // The running step keeps the period it started with; a new speed takes
   // effect only when the count restarts.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         last_q <= PRE_LAST;
      end else if (press || tick) begin
         last_q <= last_sel;
      end
   end

   assign pre_last = last_q;
`else
   assign pre_last = PRE_LAST;
`endif

   assign tick = !pause_i && (pre_cnt == pre_last);

   always_comb begin
      pat_next = pat_q;
      dir_next = dir_q;
      unique case (mode_q)
         MODE_ROT_L:  pat_next = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
         MODE_ROT_R:  pat_next = {pat_q[0], pat_q[N_LEDS-1:1]};
         MODE_BOUNCE: begin
            // direction turns on the step that lands on an end bit
            if (dir_q == DIR_LEFT) begin
               pat_next = pat_q << 1;
               if (pat_next[N_LEDS-1]) dir_next = DIR_RIGHT;
            end else begin
               pat_next = pat_q >> 1;
               if (pat_next[0]) dir_next = DIR_LEFT;
            end
         end
         MODE_FILL:   pat_next = (&pat_q) ? '0 : {pat_q[N_LEDS-2:0], 1'b1};
         default:     pat_next = pat_q;
      endcase
   end

   // A press outranks a coincident tick: the step is dropped and the count restarts.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pre_cnt <= '0;
         mode_q  <= MODE_ROT_L;
         pat_q   <= PAT_INIT;
         dir_q   <= DIR_LEFT;
         step_o  <= 1'b0;
      end else begin
         step_o <= 1'b0;
         if (press) begin
            pre_cnt <= '0;
            mode_q  <= mode_t'(mode_q + 2'd1);
            pat_q   <= PAT_INIT;
            dir_q   <= DIR_LEFT;
         end else if (tick) begin
            pre_cnt <= '0;
            pat_q   <= pat_next;
            dir_q   <= dir_next;
            step_o  <= 1'b1;
         end else if (!pause_i) begin
            pre_cnt <= pre_cnt + 1'b1;
         end
      end
   end

   assign LED    = ACTIVE_LOW ? ~pat_q : pat_q;
   assign mode_o = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
module tb_led_pattern_seq;

   localparam int N    = 4;
   localparam int STEP = 4;
   localparam int DEB  = 3;

   logic         CLK     = 1'b0;
   logic         nRST    = 1'b0;
   logic         btn_n   = 1'b1;
   logic         pause_i = 1'b0;
`ifdef LED_SEQ_SPEED_EN
   logic [1:0]   speed_i = 2'd0;
`endif
   logic [N-1:0] LED;
   logic [1:0]   mode_o;
   logic         step_o;

   led_pattern_seq #(
      .N_LEDS         (N),
      .STEP_CYCLES    (STEP),
      .DEBOUNCE_CYCLES(DEB),
      .ACTIVE_LOW     (1)
   ) dut (
      .CLK    (CLK),
      .nRST   (nRST),
      .btn_n  (btn_n),
      .pause_i(pause_i),
`ifdef LED_SEQ_SPEED_EN
      .speed_i(speed_i),
`endif
      .LED    (LED),
      .mode_o (mode_o),
      .step_o (step_o)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int           stamp;
      bit           is_step;
      logic [N-1:0] led;
      logic [1:0]   mode;
   } ev_t;

   ev_t sb[$];
   int  vectors = 0;
   int  errors  = 0;

   // reference model state
   int  m_mode;
   int  m_k;
   int  m_phase;
   bit  m_deb;
   bit  m_press_pend;
   bit  raw_hist[$];

   // pattern after k steps in a mode, from the sequence definitions
   function automatic logic [N-1:0] exp_pat(input int mode, input int k);
      logic [N-1:0] r;
      int p;
      r = '0;
      case (mode)
         0: r = N'(1) << (k % N);
         1: r = N'(1) << ((N - (k % N)) % N);
         2: begin
            p = k % (2*N - 2);
            r = N'(1) << ((p < N) ? p : (2*N - 2 - p));
         end
         default: begin
            p = k % (N + 1);
            r = (p == N) ? '0 : N'((1 << (p + 1)) - 1);
         end
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_k = 0;
      m_phase = 0;
      m_deb = 1'b1;
      m_press_pend = 1'b0;
      raw_hist.delete();
      repeat (DEB + 2) raw_hist.push_back(1'b1);
   endtask

   task automatic push_ev(input int stamp, input bit is_step);
      ev_t e;
      e.stamp   = stamp;
      e.is_step = is_step;
      e.led     = ~exp_pat(m_mode, m_k);
      e.mode    = 2'(m_mode);
      sb.push_back(e);
   endtask

   // advance the model across one clock edge with the given inputs
   task automatic model_edge(input int stamp, input bit p, input bit b);
      bit flip;
      raw_hist.push_back(b);
      if (raw_hist.size() > 16) void'(raw_hist.pop_front());
      if (m_press_pend) begin
         m_press_pend = 1'b0;
         m_mode = (m_mode + 1) % 4;
         m_k = 0;
         m_phase = 0;
         push_ev(stamp, 1'b0);
      end else if (!p) begin
         if (m_phase == STEP - 1) begin
            m_phase = 0;
            m_k++;
            push_ev(stamp, 1'b1);
         end else begin
            m_phase++;
         end
      end
      // button seen two edges late; DEB unbroken differing samples flip the level
      flip = 1'b1;
      for (int i = 0; i < DEB; i++)
         if (raw_hist[raw_hist.size() - 3 - i] == m_deb) flip = 1'b0;
      if (flip) begin
         m_deb = !m_deb;
         if (!m_deb) m_press_pend = 1'b1;
      end
   endtask

   task automatic drive(input bit p, input bit b);
      @(negedge CLK);
      #1;
      pause_i = p;
      btn_n   = b;
      model_edge(cyc + 1, p, b);
   endtask

   logic [N-1:0] hold_led  = 4'b1110;
   logic [1:0]   last_mode = 2'd0;
   ev_t          miss_e;

   task automatic do_reset();
      @(negedge CLK);
      #1;
      nRST    = 1'b0;
      pause_i = 1'b0;
      btn_n   = 1'b1;
      #1;
      vectors++;
      if (LED !== 4'b1110 || mode_o !== 2'd0 || step_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_values t=%0t: got led=%b mode=%0d step=%0b, required led=1110 mode=0 step=0",
                  $time, LED, mode_o, step_o);
      end
      sb.delete();
      model_reset();
      last_mode = 2'd0;
      hold_led  = 4'b1110;
      #1;
      nRST = 1'b1;
      model_edge(cyc + 1, 1'b0, 1'b1);
   endtask

   task automatic check_event(input bit want_step);
      ev_t e;
      vectors++;
      if (sb.size() == 0 || sb[0].stamp != cyc) begin
         errors++;
         $display("FAIL %s_unexpected cyc=%0d: got led=%b mode=%0d step=%0b, required no event here",
                  want_step ? "step" : "mode", cyc, LED, mode_o, step_o);
      end else begin
         e = sb.pop_front();
         if (e.is_step != want_step || LED !== e.led || mode_o !== e.mode || step_o !== e.is_step) begin
            errors++;
            $display("FAIL %s_event cyc=%0d: got step=%0b led=%b mode=%0d, required step=%0b led=%b mode=%0d",
                     want_step ? "step" : "mode", cyc, step_o, LED, mode_o, e.is_step, e.led, e.mode);
         end
         hold_led = e.led;
      end
   endtask

   // monitor: consumes expected events whenever the DUT shows a step or mode change
   always @(negedge CLK) begin
      if (nRST) begin
         while (sb.size() > 0 && sb[0].stamp < cyc) begin
            miss_e = sb.pop_front();
            vectors++;
            errors++;
            $display("FAIL missed_%s cyc=%0d: got no event, required led=%b mode=%0d at cyc=%0d",
                     miss_e.is_step ? "step" : "mode", cyc, miss_e.led, miss_e.mode, miss_e.stamp);
         end
         if (step_o === 1'b1) check_event(1'b1);
         if (mode_o !== last_mode) begin
            check_event(1'b0);
            last_mode = mode_o;
         end
         vectors++;
         if (LED !== hold_led) begin
            errors++;
            $display("FAIL led_hold cyc=%0d: got led=%b, required led=%b", cyc, LED, hold_led);
         end
      end
   end

   initial begin
      bit cur_b;
      int run_left;
      model_reset();
      repeat (2) @(negedge CLK);

      // free-running ROT_L after reset
      do_reset();
      repeat (17) drive(1'b0, 1'b1);

      // pause mid-count
      repeat (2) drive(1'b0, 1'b1);
      repeat (10) drive(1'b1, 1'b1);
      repeat (12) drive(1'b0, 1'b1);

      // glitch (no press), then a real press and release
      repeat (2) drive(1'b0, 1'b0);
      repeat (10) drive(1'b0, 1'b1);
      repeat (6) drive(1'b0, 1'b0);
      repeat (12) drive(1'b0, 1'b1);

      // into BOUNCE for 8+ steps, then FILL for 5+ steps
      repeat (6) drive(1'b0, 1'b0);
      repeat (40) drive(1'b0, 1'b1);
      repeat (6) drive(1'b0, 1'b0);
      repeat (26) drive(1'b0, 1'b1);

      // press timed to land on a tick edge
      for (int g = 0; g < 8 && m_phase != 2; g++) drive(1'b0, 1'b1);
      repeat (6) drive(1'b0, 1'b0);
      repeat (14) drive(1'b0, 1'b1);

      // reset pulse mid-count, then press while paused
      repeat (6) drive(1'b0, 1'b1);
      do_reset();
      repeat (6) drive(1'b0, 1'b1);
      repeat (6) drive(1'b1, 1'b0);
      repeat (6) drive(1'b1, 1'b1);
      repeat (10) drive(1'b0, 1'b1);

      // randomised button runs and pauses
      cur_b = 1'b1;
      run_left = 10;
      for (int i = 0; i < 1500; i++) begin
         if (run_left == 0) begin
            cur_b = !cur_b;
            run_left = cur_b ? $urandom_range(1, 24) : $urandom_range(1, 6);
         end
         run_left--;
         if (i == 800) do_reset();
         drive($urandom_range(0, 7) == 0, cur_b);
      end
      repeat (12) drive(1'b0, 1'b1);

      @(negedge CLK);
      #2;
      while (sb.size() > 0) begin
         miss_e = sb.pop_front();
         vectors++;
         errors++;
         $display("FAIL leftover_event: got none, required led=%b mode=%0d at cyc=%0d",
                  miss_e.led, miss_e.mode, miss_e.stamp);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
